trajectory_engine: RTL
======================

// Module: trajectory_engine
// PURPOSE
//  Parametrised successor to the 5-bit trajectory calculator. It steps a projectile from
//  (x_pos,0) by (±run,+rise) each cycle. It reflects off the side walls at 0 and XMAX, tests
//  each point against a target window, and reports hit, step count and end reason.
//  Sits between the player-input logic and the score/display logic; one shot at a time.
// PARAMETERS
//  W          5   coordinate width; XMAX = YMAX = 2**W-1
//  STEP_W     6   width of step counter
//  MAX_STEPS  63  step cap; forces termination (covers rise=0); must be < 2**STEP_W
//  TOL        0   hit tolerance: |x-tx|<=TOL and |y-ty|<=TOL
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  shoot         in   1       start request; accepted only when ready=1
//  ready         out  1       1 in IDLE only
//  x_pos         in   W       launch x
//  rise_in       in   W       y increment per step
//  run_in        in   W       |x| increment per step; must be <= XMAX
//  direction_in  in   1       initial x direction: 0=left, 1=right
//  target_x      in   W       target x, sampled at accept
//  target_y      in   W       target y, sampled at accept
//  result_valid  out  1       held high in DONE until result_ack
//  result_ack    in   1       consumer ack; DONE->IDLE
//  hit           out  1       1 = target window reached
//  end_reason    out  2       00 HIT, 01 CEILING, 10 STEP_LIMIT
//  hit_steps     out  STEP_W  step index of the terminating point
//  positionx     out  W       current/final x
//  positiony     out  W       current/final y
// BEHAVIOUR
//  - Reset (async): state IDLE. All outputs 0 except ready=1. Reset mid-CALC aborts with no result.
//  - States:
//    IDLE -shoot-> CALC
//    CALC -terminate-> DONE
//    DONE -result_ack-> IDLE
//    Undefined encodings -> IDLE.
//  - Accept edge: latch rise, run, dir, targets. cur=(x_pos,0), steps=0.
//  - CALC, each cycle: evaluate the current point, in priority order:
//    1. in target window -> DONE, reason HIT, hit=1
//    2. cur_y+rise > YMAX (W+1-bit sum) -> DONE, reason CEILING
//    3. steps==MAX_STEPS -> DONE, reason STEP_LIMIT
//    4. otherwise advance: y+=rise, steps+=1, x per reflection rule below.
//  - Reflection (W+1-bit arithmetic):
//    right: s=x+run; if s>XMAX then x'=2*XMAX-s, dir'=0; else x'=s
//    left:  if run>x then x'=run-x, dir'=1; else x'=x-run
//    Landing exactly on 0 or XMAX does not flip direction.
//  - Window: compare with W+1-bit absolute difference; no wrap.
//  - Latency: N = index of terminating point; result_valid rises N+1 clocks after the accept edge.
//  - DONE: hit, end_reason, hit_steps, positionx/y frozen. shoot ignored. result_ack in same
//    cycle as entry is honoured on the next edge. result_ack outside DONE is ignored.
//  - IDLE: shoot and result_ack together -> shoot accepted.
//  - Inputs x_pos, rise_in, run_in and targets are don't-care outside the accept cycle.
// STRUCTURE
//  - Package trajectory_pkg: state enum (IDLE, CALC, DONE); end-reason codes
//    (END_HIT, END_CEILING, END_LIMIT).
//  - Sub-module trajectory_reflect #(W): combinational (x, run, dir) -> (x', dir').
//  - Top holds FSM, registers and window compare. Registers use the codebase async-reset flop.
// TESTING
//  (W=5, MAX_STEPS=63, TOL=0 unless stated)
//  1. x=10, rise=3, run=2, right, tgt(14,6) -> points (10,0),(12,3),(14,6);
//     hit=1, reason 00, hit_steps=2, result_valid 3 clks after accept.
//  2. x=29, run=4, right, rise=1 -> next x=29, dir=left. x=2, run=5, left -> next x=3, dir=right.
//  3. x=5, rise=16, run=0, tgt(0,0) -> y 0,16, then 32>31; reason 01, hit=0, hit_steps=1.
//  4. rise=0, run=1, tgt unreachable -> reason 10, hit_steps=63, valid held until ack.
//  5. TOL=1, tgt(13,6), same shot as 1 -> hit at step 2. Reset mid-CALC -> ready=1, valid=0
//     at once. shoot during DONE ignored.
//  6. Back-to-back: ack and shoot in consecutive cycles -> second shot's results independent
//     of the first.

Source files
------------

// File: rtl/trajectory_pkg.sv
// Shared types for the trajectory engine: controller states and end-reason codes.
package trajectory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    END_HIT     = 2'b00,
    END_CEILING = 2'b01,
    END_LIMIT   = 2'b10
  } end_reason_t;

endpackage

// File: rtl/trajectory_reflect.sv
// One horizontal step of the projectile, bouncing off the walls at 0 and XMAX.
// Landing exactly on a wall keeps the current direction.
module trajectory_reflect
  import trajectory_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_run,
  input  logic         i_dir,
  output logic [W-1:0] o_x,
  output logic         o_dir
);

  localparam logic [W:0] XMAX_EXT   = {1'b0, {W{1'b1}}};
  localparam logic [W:0] TWICE_XMAX = {{W{1'b1}}, 1'b0};

  logic [W:0] w_sum;

  assign w_sum = {1'b0, i_x} + {1'b0, i_run};

  // Fold overshoots back inside the field; run never exceeds XMAX so one fold is enough.
  always_comb begin
    o_x   = i_x;
    o_dir = i_dir;
    if (i_dir) begin
      if (w_sum > XMAX_EXT) begin
        o_x   = W'(TWICE_XMAX - w_sum);
        o_dir = 1'b0;
      end else begin
        o_x = w_sum[W-1:0];
      end
    end else begin
      if (i_run > i_x) begin
        o_x   = i_run - i_x;
        o_dir = 1'b1;
      end else begin
        o_x = i_x - i_run;
      end
    end
  end

endmodule

// File: rtl/trajectory_engine.sv
// Steps one projectile shot at a time, bouncing off the side walls, and reports
// whether it entered the target window, at which step, and why it stopped.
module trajectory_engine
  import trajectory_pkg::*;
#(
  parameter int W         = 5,
  parameter int STEP_W    = 6,
  parameter int MAX_STEPS = 63,
  parameter int TOL       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shoot,
  output logic              ready,
  input  logic [W-1:0]      x_pos,
  input  logic [W-1:0]      rise_in,
  input  logic [W-1:0]      run_in,
  input  logic              direction_in,
  input  logic [W-1:0]      target_x,
  input  logic [W-1:0]      target_y,
  output logic              result_valid,
  input  logic              result_ack,
  output logic              hit,
  output logic [1:0]        end_reason,
  output logic [STEP_W-1:0] hit_steps,
  output logic [W-1:0]      positionx,
  output logic [W-1:0]      positiony
);

  localparam logic [W:0]        YMAX_EXT = {1'b0, {W{1'b1}}};
  localparam logic [W:0]        TOL_EXT  = (W+1)'(TOL);
  localparam logic [STEP_W-1:0] STEP_CAP = STEP_W'(MAX_STEPS);

  state_t              r_state;
  state_t              w_next_state;

  logic [W-1:0]        r_x;
  logic [W-1:0]        r_y;
  logic [W-1:0]        r_rise;
  logic [W-1:0]        r_run;
  logic [W-1:0]        r_tx;
  logic [W-1:0]        r_ty;
  logic                r_dir;
  logic [STEP_W-1:0]   r_steps;
  logic                r_hit;
  end_reason_t         r_reason;

  logic                w_accept;
  logic                w_advance;
  logic                w_term;
  logic                w_term_hit;
  end_reason_t         w_reason;

  logic [W-1:0]        w_next_x;
  logic                w_next_dir;
  logic [W:0]          w_dx;
  logic [W:0]          w_dy;
  logic [W:0]          w_y_sum;
  logic                w_in_window;
  logic                w_ceiling;
  logic                w_limit;

  trajectory_reflect #(
    .W(W)
  ) u_reflect (
    .i_x   (r_x),
    .i_run (r_run),
    .i_dir (r_dir),
    .o_x   (w_next_x),
    .o_dir (w_next_dir)
  );

  // Termination tests on the current point: window distance, ceiling overflow, step cap.
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    if ({1'b0, r_x} >= {1'b0, r_tx}) begin
      w_dx = {1'b0, r_x} - {1'b0, r_tx};
    end else begin
      w_dx = {1'b0, r_tx} - {1'b0, r_x};
    end
    if ({1'b0, r_y} >= {1'b0, r_ty}) begin
      w_dy = {1'b0, r_y} - {1'b0, r_ty};
    end else begin
      w_dy = {1'b0, r_ty} - {1'b0, r_y};
    end
    w_y_sum     = {1'b0, r_y} + {1'b0, r_rise};
    w_in_window = (w_dx <= TOL_EXT) && (w_dy <= TOL_EXT);
    w_ceiling   = (w_y_sum > YMAX_EXT);
    w_limit     = (r_steps == STEP_CAP);
  end

  // Controller state register; reset abandons any shot in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode; hit beats ceiling beats step cap.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    w_term       = 1'b0;
    w_term_hit   = 1'b0;
    w_reason     = END_HIT;
    ready        = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (shoot) begin
          w_accept     = 1'b1;
          w_next_state = CALC;
        end
      end
      CALC: begin
        if (w_in_window) begin
          w_term       = 1'b1;
          w_term_hit   = 1'b1;
          w_reason     = END_HIT;
          w_next_state = DONE;
        end else if (w_ceiling) begin
          w_term       = 1'b1;
          w_reason     = END_CEILING;
          w_next_state = DONE;
        end else if (w_limit) begin
          w_term       = 1'b1;
          w_reason     = END_LIMIT;
          w_next_state = DONE;
        end else begin
          w_advance = 1'b1;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ack) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Shot datapath: load on accept, step while calculating, freeze the result on termination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_rise   <= '0;
      r_run    <= '0;
      r_tx     <= '0;
      r_ty     <= '0;
      r_dir    <= 1'b0;
      r_steps  <= '0;
      r_hit    <= 1'b0;
      r_reason <= END_HIT;
    end else if (w_accept) begin
      r_x      <= x_pos;
      r_y      <= '0;
      r_rise   <= rise_in;
      r_run    <= run_in;
      r_tx     <= target_x;
      r_ty     <= target_y;
      r_dir    <= direction_in;
      r_steps  <= '0;
      r_hit    <= 1'b0;
      r_reason <= END_HIT;
    end else if (w_advance) begin
      r_x     <= w_next_x;
      r_dir   <= w_next_dir;
      r_y     <= r_y + r_rise;
      r_steps <= r_steps + STEP_W'(1);
    end else if (w_term) begin
      r_hit    <= w_term_hit;
      r_reason <= w_reason;
    end
  end

  assign hit        = r_hit;
  assign end_reason = r_reason;
  assign hit_steps  = r_steps;
  assign positionx  = r_x;
  assign positiony  = r_y;

endmodule
